// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx bus arbiter: widths, address layout, FSM encoding, txn payload.
package fx_bus_pkg;

    localparam int unsigned FX_AW     = 16;
    localparam int unsigned FX_DW     = 8;
    localparam int unsigned FX_MOD_W  = 6;
    localparam int unsigned FX_REG_W  = 8;
    localparam int unsigned FX_RSVD_W = FX_AW - FX_MOD_W - FX_REG_W;

    // fx address: [15:14] unused, [13:8] module id, [7:0] register
    typedef struct packed {
        logic [FX_RSVD_W-1:0] rsvd;
        logic [FX_MOD_W-1:0]  mod_id;
        logic [FX_REG_W-1:0]  regn;
    } fx_addr_t;

    // Transaction latched from the granted requester
    typedef struct packed {
        logic                 wr;
        fx_addr_t             addr;
        logic [FX_DW-1:0]     wdata;
    } fx_txn_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_ACK  = 3'd4
    } fx_state_e;

endpackage

// File: rtl/fx_arb_rr2.sv
// Two-way round-robin arbiter; pointer remembers the last accepted grant.
module fx_arb_rr2 (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_valid_c,
    output logic       gnt_id_c,
    output logic       last_o
);

    logic last_q;
    logic last_d;

    // Grant selection: lone requester wins, a tie goes to the one not served last
    always_comb begin
        gnt_valid_c = |req_i;
        gnt_id_c    = 1'b0;
        last_d      = last_q;
        unique case (req_i)
            2'b01:   gnt_id_c = 1'b0;
            2'b10:   gnt_id_c = 1'b1;
            2'b11:   gnt_id_c = ~last_q;
            default: gnt_id_c = 1'b0;
        endcase
        if (accept_i && gnt_valid_c) begin
            last_d = gnt_id_c;
        end
    end

    // Pointer register; resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/fx_bus_arb.sv
// fx bus master shared by two requesters: arbitrate, run one write/read strobe, ack the winner.
module fx_bus_arb
    import fx_bus_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             req0,
    input  logic             wr0,
    input  logic [FX_AW-1:0] addr0,
    input  logic [FX_DW-1:0] wdata0,
    output logic             ack0,
    output logic [FX_DW-1:0] rdata0,
    input  logic             req1,
    input  logic             wr1,
    input  logic [FX_AW-1:0] addr1,
    input  logic [FX_DW-1:0] wdata1,
    output logic             ack1,
    output logic [FX_DW-1:0] rdata1,
    output logic             fx_wr,
    output logic [FX_AW-1:0] fx_waddr,
    output logic [FX_DW-1:0] fx_data,
    output logic             fx_rd,
    output logic [FX_AW-1:0] fx_raddr,
    input  logic [FX_DW-1:0] fx_q,
    output logic             busy,
    output logic             gnt_id
);

    fx_state_e        state_q, state_d;
    fx_txn_t          txn_q, txn_d;
    fx_txn_t          sel_txn;
    logic             gnt_valid_c;
    logic             gnt_id_c;
    logic             last_id;

    logic             fx_wr_q, fx_wr_d;
    logic [FX_AW-1:0] fx_waddr_q, fx_waddr_d;
    logic [FX_DW-1:0] fx_data_q, fx_data_d;
    logic             fx_rd_q, fx_rd_d;
    logic [FX_AW-1:0] fx_raddr_q, fx_raddr_d;
    logic [1:0]       ack_q, ack_d;
    logic [FX_DW-1:0] rdata0_q, rdata0_d;
    logic [FX_DW-1:0] rdata1_q, rdata1_d;
    logic             busy_q, busy_d;

    fx_arb_rr2 u_arb (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .req_i       ({req1, req0}),
        .accept_i    (state_q == ST_IDLE),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c),
        .last_o      (last_id)
    );

    // Candidate transaction from whichever requester the arbiter picks
    always_comb begin
        if (gnt_id_c) begin
            sel_txn = fx_txn_t'{wr1, fx_addr_t'(addr1), wdata1};
        end else begin
            sel_txn = fx_txn_t'{wr0, fx_addr_t'(addr0), wdata0};
        end
    end

    // State and latched transaction registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
        end
    end

    // Next state; requester inputs are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    txn_d   = sel_txn;
                    state_d = sel_txn.wr ? ST_WR : ST_RD;
                end
            end
            ST_WR:   state_d = ST_ACK;
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values decoded from the upcoming state so registered outputs align with it
    always_comb begin
        fx_wr_d    = 1'b0;
        fx_waddr_d = '0;
        fx_data_d  = '0;
        fx_rd_d    = 1'b0;
        fx_raddr_d = '0;
        ack_d      = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = (state_d != ST_IDLE);
        if (state_d == ST_WR) begin
            fx_wr_d    = 1'b1;
            fx_waddr_d = txn_d.addr;
            fx_data_d  = txn_d.wdata;
        end
        if (state_d == ST_RD) begin
            fx_rd_d    = 1'b1;
            fx_raddr_d = txn_d.addr;
        end
        if (state_d == ST_ACK) begin
            ack_d = last_id ? 2'b10 : 2'b01;
        end
        // Slave answers during CAP; capture into the served requester's read register
        if (state_q == ST_CAP) begin
            if (last_id) begin
                rdata1_d = fx_q;
            end else begin
                rdata0_d = fx_q;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fx_wr_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_data_q  <= '0;
            fx_rd_q    <= 1'b0;
            fx_raddr_q <= '0;
            ack_q      <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            fx_wr_q    <= fx_wr_d;
            fx_waddr_q <= fx_waddr_d;
            fx_data_q  <= fx_data_d;
            fx_rd_q    <= fx_rd_d;
            fx_raddr_q <= fx_raddr_d;
            ack_q      <= ack_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign fx_wr    = fx_wr_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_data  = fx_data_q;
    assign fx_rd    = fx_rd_q;
    assign fx_raddr = fx_raddr_q;
    assign ack0     = ack_q[0];
    assign ack1     = ack_q[1];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign gnt_id   = last_id;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb: vector table, bus/ack scoreboard, slave model, corner sequences.
module tb_fx_bus_arb;
    import fx_bus_pkg::*;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        req_v   [2];
    logic        wr_v    [2];
    logic [15:0] addr_v  [2];
    logic [7:0]  wdata_v [2];
    logic        ack0, ack1;
    logic [7:0]  rdata0, rdata1;
    logic        fx_wr, fx_rd;
    logic [15:0] fx_waddr, fx_raddr;
    logic [7:0]  fx_data;
    logic [7:0]  fx_q;
    logic        busy, gnt_id;

    typedef struct {
        int          id;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [15:0] waddr;
        logic [15:0] raddr;
        logic [7:0]  data;
    } bus_t;

    typedef struct packed {
        logic       id;
        logic [7:0] rdata;
    } ackx_t;

    bus_t       bus_q[$];
    ackx_t      ack_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rd [2];
    vec_t       tbl [11];
    logic [7:0] mem [256];
    fx_addr_t   ra_s, wa_s;

    always #5 clk_sys = ~clk_sys;

    fx_bus_arb dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .req0     (req_v[0]),
        .wr0      (wr_v[0]),
        .addr0    (addr_v[0]),
        .wdata0   (wdata_v[0]),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req_v[1]),
        .wr1      (wr_v[1]),
        .addr1    (addr_v[1]),
        .wdata1   (wdata_v[1]),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .busy     (busy),
        .gnt_id   (gnt_id)
    );

    // Slave model: module 0x03 is mapped to a 256-byte register file, everything else reads 0
    assign ra_s = fx_raddr;
    assign wa_s = fx_waddr;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        fx_q = 8'h00;
    end
    always @(posedge clk_sys) begin
        fx_q <= (fx_rd && ra_s.mod_id == 6'h03) ? mem[ra_s.regn] : 8'h00;
        if (fx_wr && wa_s.mod_id == 6'h03) mem[wa_s.regn] <= fx_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_fx"}, 64'({fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data}), 64'(0));
        chk({nm, "_ack"}, 64'({ack0, ack1}), 64'(0));
        chk({nm, "_rdata"}, 64'({rdata0, rdata1}), 64'(0));
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_gnt_id"}, 64'(gnt_id), 64'(1));
    endtask

    // Bus/ack monitor: every strobe and every ack must match the next scoreboard entry
    always @(negedge clk_sys) begin
        if (!rst) begin
            bus_t  act_b;
            bus_t  e_b;
            ackx_t e_a;
            chk("excl_wr_rd", 64'(fx_wr & fx_rd), 64'(0));
            chk("excl_ack", 64'(ack0 & ack1), 64'(0));
            if (fx_wr || fx_rd) begin
                act_b = '{fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data};
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected actual=0x%0h required=none", act_b);
                end else begin
                    e_b = bus_q.pop_front();
                    chk("bus_strobe", 64'(act_b), 64'(e_b));
                end
            end else begin
                chk("bus_idle_zero", 64'({fx_waddr, fx_raddr, fx_data}), 64'(0));
            end
            if (ack0 || ack1) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=%b%b required=none", ack1, ack0);
                end else begin
                    e_a = ack_q.pop_front();
                    chk("ack_id_rdata", 64'({ack1, ack1 ? rdata1 : rdata0}), 64'(e_a));
                end
            end
        end
    end

    // One requester transaction with scoreboard push, latency and hold checks
    task automatic run_req(input vec_t v, input string nm);
        int    n;
        bit    got;
        int    oth;
        bus_t  eb;
        ackx_t ea;
        eb.wr    = v.wr;
        eb.rd    = ~v.wr;
        eb.waddr = v.wr ? v.addr : 16'h0000;
        eb.raddr = v.wr ? 16'h0000 : v.addr;
        eb.data  = v.wr ? v.wdata : 8'h00;
        if (!v.wr) exp_rd[v.id] = v.exp_rdata;
        ea.id    = 1'(v.id);
        ea.rdata = exp_rd[v.id];
        bus_q.push_back(eb);
        ack_q.push_back(ea);
        req_v[v.id]   = 1'b1;
        wr_v[v.id]    = v.wr;
        addr_v[v.id]  = v.addr;
        wdata_v[v.id] = v.wdata;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk_sys);
            n++;
            got = (v.id == 1) ? ack1 : ack0;
        end
        chk({nm, "_latency"}, 64'(got ? n : 99), 64'(v.exp_lat));
        req_v[v.id] = 1'b0;
        oth = 1 - v.id;
        chk({nm, "_other_rdata"}, 64'((oth == 1) ? rdata1 : rdata0), 64'(exp_rd[oth]));
        @(negedge clk_sys);
    endtask

    // Requester that keeps issuing reads, dropping req for a cycle after each ack
    task automatic rr_requester(input int id, input logic [15:0] a, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            int n;
            bit got;
            req_v[id]  = 1'b1;
            wr_v[id]   = 1'b0;
            addr_v[id] = a;
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk_sys);
                n++;
                got = (id == 1) ? ack1 : ack0;
            end
            chk($sformatf("rr_req%0d_done%0d", id, k), 64'(got), 64'(1));
            req_v[id] = 1'b0;
            @(negedge clk_sys);
            @(negedge clk_sys);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus_t  eb;
        ackx_t ea;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = 16'h0000; wdata_v[i] = 8'h00;
            exp_rd[i] = 8'h00;
        end

        //               id wr    addr      wdata  rdata  lat
        tbl[0]  = '{0, 1'b1, 16'h0381, 8'h5A, 8'h00, 2};
        tbl[1]  = '{1, 1'b0, 16'h0381, 8'h00, 8'h5A, 3};
        tbl[2]  = '{0, 1'b0, 16'h3F10, 8'h00, 8'h00, 3};
        tbl[3]  = '{1, 1'b1, 16'h0302, 8'hC3, 8'h00, 2};
        tbl[4]  = '{0, 1'b0, 16'h0302, 8'h00, 8'hC3, 3};
        tbl[5]  = '{0, 1'b1, 16'h0381, 8'h11, 8'h00, 2};
        tbl[6]  = '{1, 1'b0, 16'h0381, 8'h00, 8'h11, 3};
        tbl[7]  = '{0, 1'b1, 16'h0500, 8'h77, 8'h00, 2};
        tbl[8]  = '{0, 1'b0, 16'h0500, 8'h00, 8'h00, 3};
        tbl[9]  = '{1, 1'b1, 16'h3FFF, 8'hFF, 8'h00, 2};
        tbl[10] = '{1, 1'b0, 16'h0302, 8'h00, 8'hC3, 3};

        repeat (3) @(negedge clk_sys);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk_sys);
        chk_reset_vals("idle_after_reset");

        for (int i = 0; i < 11; i++) begin
            run_req(tbl[i], $sformatf("vec%0d", i));
        end

        // Inputs changed while a write is in flight: strobe must carry the latched values
        eb = '{1'b1, 1'b0, 16'h0303, 16'h0000, 8'h44};
        ea = '{1'b0, exp_rd[0]};
        bus_q.push_back(eb);
        ack_q.push_back(ea);
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'h0303; wdata_v[0] = 8'h44;
        @(negedge clk_sys);
        chk("tog_wr_busy", 64'(busy), 64'(1));
        req_v[0] = 1'b0; addr_v[0] = 16'h0399; wdata_v[0] = 8'hEE;
        @(negedge clk_sys);
        chk("tog_wr_ack", 64'(ack0), 64'(1));
        @(negedge clk_sys);

        // Other requester pulses req during RD/CAP: must not be served
        eb = '{1'b0, 1'b1, 16'h0000, 16'h0302, 8'h00};
        exp_rd[0] = 8'hC3;
        ea = '{1'b0, 8'hC3};
        bus_q.push_back(eb);
        ack_q.push_back(ea);
        req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 16'h0302;
        @(negedge clk_sys);
        req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 16'h0301; wdata_v[1] = 8'h99;
        req_v[0] = 1'b0;
        @(negedge clk_sys);
        req_v[1] = 1'b0; addr_v[0] = 16'h3F00;
        @(negedge clk_sys);
        chk("tog_rd_ack_rdata", 64'({ack0, rdata0}), 64'({1'b1, 8'hC3}));
        repeat (4) @(negedge clk_sys);
        chk("tog_gnt_id", 64'(gnt_id), 64'(0));

        // Reset while in CAP: no ack, outputs return to reset values immediately
        eb = '{1'b0, 1'b1, 16'h0000, 16'h0381, 8'h00};
        bus_q.push_back(eb);
        req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 16'h0381;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("cap_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        req_v[0] = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        #1;
        chk_reset_vals("rst_in_cap");
        repeat (2) @(negedge clk_sys);
        chk_reset_vals("rst_held");
        chk("rst_bus_q_consumed", 64'(bus_q.size()), 64'(0));
        rst = 1'b0;
        @(negedge clk_sys);
        chk("rst_no_late_ack", 64'({ack0, ack1}), 64'(0));
        run_req('{1, 1'b1, 16'h0310, 8'h3C, 8'h00, 2}, "post_rst_wr");
        run_req('{1, 1'b0, 16'h0310, 8'h00, 8'h3C, 3}, "post_rst_rd");

        // Both requesters reading from reset: served 0,1,0,1
        rst = 1'b1;
        @(negedge clk_sys);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            bus_q.push_back('{1'b0, 1'b1, 16'h0000, 16'h0381, 8'h00});
            ack_q.push_back('{1'b0, 8'h11});
            bus_q.push_back('{1'b0, 1'b1, 16'h0000, 16'h0302, 8'h00});
            ack_q.push_back('{1'b1, 8'hC3});
        end
        rst = 1'b0;
        fork
            rr_requester(0, 16'h0381, 2);
            rr_requester(1, 16'h0302, 2);
        join
        repeat (2) @(negedge clk_sys);
        chk("end_bus_q_empty", 64'(bus_q.size()), 64'(0));
        chk("end_ack_q_empty", 64'(ack_q.size()), 64'(0));
        chk("end_rdata", 64'({rdata0, rdata1}), 64'({8'h11, 8'hC3}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_bus_arb.md
FX_BUS_ARB -- requirements
Module: fx_bus_arb

Interface
REQ-001 SHALL have ports: clk_sys  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have, per requester k in {0,1}: reqk in 1 (transaction request); wrk in 1 (1=write, 0=read); addrk in 16 (fx address, [13:8]=mod_id, [7:0]=register); wdatak in 8 (write data); ackk out 1 (one-cycle done pulse); rdatak out 8 (read data, valid with ackk).
REQ-004 SHALL drive fx bus master outputs: fx_wr out 1; fx_waddr out 16; fx_data out 8; fx_rd out 1; fx_raddr out 16.
REQ-005 SHALL have: fx_q in 8 (wired-OR slave read data; non-selected slaves drive 0; selected slave registers q one cycle after fx_rd).
REQ-006 SHALL have status: busy out 1 (FSM not IDLE); gnt_id out 1 (requester currently or last served).

Function
REQ-007 SHALL implement FSM states IDLE, WR, RD, CAP, ACK.
REQ-008 IDLE: any reqk=1 -> grant one requester, latch its wr/addr/wdata; next state WR if wr=1, else RD; no request -> stay IDLE.
REQ-009 Arbitration: single request -> that requester; both -> round-robin, grant the one not granted last; pointer after reset favours requester 0.
REQ-010 WR: fx_wr=1, fx_waddr=latched addr, fx_data=latched wdata, exactly one cycle; next ACK.
REQ-011 RD: fx_rd=1, fx_raddr=latched addr, exactly one cycle; next CAP.
REQ-012 CAP: register fx_q into rdata of granted requester; next ACK.
REQ-013 ACK: ack of granted requester =1 for exactly one cycle; next IDLE.
REQ-014 All fx outputs and ack SHALL be registered; fx_wr/fx_rd/fx_waddr/fx_raddr/fx_data =0 outside WR/RD.
REQ-015 Latency from IDLE grant edge: write ack at +2 cycles, read ack at +3 cycles; minimum back-to-back spacing 3 (write) / 4 (read) cycles incl. IDLE.
REQ-016 Requester SHALL hold req/wr/addr/wdata stable until ack and deassert req in cycle after ack; block samples inputs only in IDLE.
REQ-017 rdatak SHALL hold last captured value until next read for that requester; writes do not alter rdatak.
REQ-018 Never both fx_wr and fx_rd high; never both ack0 and ack1 high.
REQ-019 Read of unmapped/unselected address returns 0x00 (fx_q=0), still acked normally; no timeout.
REQ-020 Request changes outside IDLE SHALL be ignored until return to IDLE.

Reset
REQ-021 rst=1 asynchronously: FSM->IDLE, fx_wr=fx_rd=0, fx_waddr=fx_raddr=0, fx_data=0, ack0=ack1=0, rdata0=rdata1=0x00, busy=0, gnt_id=1 (pointer so requester 0 wins first tie).
REQ-022 Reset mid-transaction SHALL abort it with no ack; first grant after release follows REQ-009.

Structure
REQ-023 Shared package fx_bus_pkg SHALL hold FSM state encoding, fx address field widths (16-bit address, [13:8] mod_id, [7:0] register) and data width 8.
REQ-024 Round-robin grant logic SHALL be sub-module fx_arb_rr2 (2 req in, grant + pointer update on accept).

Verification
REQ-025 Write: req0, wr0=1, addr0=0x0381, wdata0=0x5A -> fx_wr one cycle with fx_waddr=0x0381, fx_data=0x5A; ack0 two cycles after grant.
REQ-026 Read: req1, wr1=0, addr1=0x0381, slave model returns 0x5A one cycle after fx_rd -> fx_raddr=0x0381, rdata1=0x5A with ack1 three cycles after grant.
REQ-027 Contention: req0,req1 both high from reset, both reads -> served 0,1,0,1 alternately; never simultaneous fx_rd/acks.
REQ-028 Unmapped read addr0=0x3F10 with fx_q=0 -> ack0, rdata0=0x00.
REQ-029 Reset asserted during CAP -> no ack, all outputs to REQ-021 values immediately; next req1 served normally.
REQ-030 Req toggled during WR/RD/CAP -> no extra fx strobes; latched addr/data unchanged.
